// File: rtl/axil_uart_pkg.sv
// Shared register map, AXI response codes and FSM state types for the
// AXI4-Lite UART register slave.
package axil_uart_pkg;

    localparam logic [1:0] ADDR_RXDATA = 2'd0;
    localparam logic [1:0] ADDR_TXDATA = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;
    localparam logic [1:0] ADDR_CTRL   = 2'd3;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic {
        W_IDLE,
        W_RESP
    } w_state_t;

    typedef enum logic {
        R_IDLE,
        R_RESP
    } r_state_t;

endpackage

// File: rtl/axil_uart_slave.sv
// AXI4-Lite slave turning register accesses into UART FIFO push/pop strobes.
// Independent write and read FSMs, one outstanding transaction each.
module axil_uart_slave
    import axil_uart_pkg::*;
#(
    parameter int C_ADDR_WIDTH = 4,
    parameter int C_DATA_WIDTH = 32
) (
    input  logic                        Clk,
    input  logic                        Resetn,

    input  logic [C_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic                        S_AXI_AWVALID,
    output logic                        S_AXI_AWREADY,

    input  logic [C_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                        S_AXI_WVALID,
    output logic                        S_AXI_WREADY,

    output logic [1:0]                  S_AXI_BRESP,
    output logic                        S_AXI_BVALID,
    input  logic                        S_AXI_BREADY,

    input  logic [C_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic                        S_AXI_ARVALID,
    output logic                        S_AXI_ARREADY,

    output logic [C_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                  S_AXI_RRESP,
    output logic                        S_AXI_RVALID,
    input  logic                        S_AXI_RREADY,

    input  logic [7:0]                  uart_rx_data,
    input  logic                        uart_rx_empty,
    output logic                        uart_rd_en,
    output logic [7:0]                  uart_tx_data,
    output logic                        uart_wr_en,
    input  logic                        uart_tx_full,
    output logic                        uart_enable_rx
);

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    w_state_t   w_state_q;
    logic       aw_held_q, w_held_q;
    logic [1:0] aw_addr_q;
    logic [7:0] w_byte_q;
    logic       w_strb0_q;
    logic       bvalid_q;
    logic [1:0] bresp_q;
    logic       wr_en_q;
    logic [7:0] tx_data_q;
    logic       ctrl_q;

    logic       aw_hs, w_hs, aw_have, w_have;
    logic [1:0] aw_addr_d;
    logic [7:0] w_byte_d;
    logic       w_strb0_d;

    // Only the decoded address bits, the low data byte and WSTRB[0] matter.
    logic       unused_bits;
    assign unused_bits = ^{S_AXI_AWADDR, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_ARADDR};

    assign S_AXI_AWREADY = (w_state_q == W_IDLE) && !aw_held_q;
    assign S_AXI_WREADY  = (w_state_q == W_IDLE) && !w_held_q;

    assign aw_hs   = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs    = S_AXI_WVALID && S_AXI_WREADY;
    assign aw_have = aw_held_q || aw_hs;
    assign w_have  = w_held_q || w_hs;

    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        aw_addr_d = aw_held_q ? aw_addr_q : S_AXI_AWADDR[3:2];
        w_byte_d  = w_held_q  ? w_byte_q  : S_AXI_WDATA[7:0];
        w_strb0_d = w_held_q  ? w_strb0_q : S_AXI_WSTRB[0];
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            w_state_q <= W_IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            aw_addr_q <= '0;
            w_byte_q  <= '0;
            w_strb0_q <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= AXI_RESP_OKAY;
            wr_en_q   <= 1'b0;
            tx_data_q <= '0;
            ctrl_q    <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            case (w_state_q)
                W_IDLE: begin
                    if (aw_have && w_have) begin
                        w_state_q <= W_RESP;
                        bvalid_q  <= 1'b1;
                        bresp_q   <= AXI_RESP_OKAY;
                        if (w_strb0_d) begin
                            case (aw_addr_d)
                                ADDR_TXDATA: begin
                                    if (uart_tx_full) begin
                                        bresp_q <= AXI_RESP_SLVERR;
                                    end else begin
                                        wr_en_q   <= 1'b1;
                                        tx_data_q <= w_byte_d;
                                    end
                                end
                                ADDR_CTRL: ctrl_q <= w_byte_d[0];
                                default: ;
                            endcase
                        end
                    end else begin
                        if (aw_hs) begin
                            aw_held_q <= 1'b1;
                            aw_addr_q <= S_AXI_AWADDR[3:2];
                        end
                        if (w_hs) begin
                            w_held_q  <= 1'b1;
                            w_byte_q  <= S_AXI_WDATA[7:0];
                            w_strb0_q <= S_AXI_WSTRB[0];
                        end
                    end
                end
                W_RESP: begin
                    if (S_AXI_BREADY) begin
                        w_state_q <= W_IDLE;
                        bvalid_q  <= 1'b0;
                        aw_held_q <= 1'b0;
                        w_held_q  <= 1'b0;
                    end
                end
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    assign S_AXI_BVALID   = bvalid_q;
    assign S_AXI_BRESP    = bresp_q;
    assign uart_wr_en     = wr_en_q;
    assign uart_tx_data   = tx_data_q;
    assign uart_enable_rx = ctrl_q;

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    r_state_t                r_state_q;
    logic                    rvalid_q;
    logic [C_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                    rd_en_q;

    assign S_AXI_ARREADY = (r_state_q == R_IDLE);

    always_comb begin
        rdata_d = '0;
        case (S_AXI_ARADDR[3:2])
            ADDR_RXDATA: if (!uart_rx_empty) rdata_d[8:0] = {1'b1, uart_rx_data};
            ADDR_STATUS: rdata_d[2:0] = {ctrl_q, uart_tx_full, !uart_rx_empty};
            ADDR_CTRL:   rdata_d[0]   = ctrl_q;
            default: ;
        endcase
    end

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            r_state_q <= R_IDLE;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rd_en_q   <= 1'b0;
        end else begin
            rd_en_q <= 1'b0;
            case (r_state_q)
                R_IDLE: begin
                    if (S_AXI_ARVALID) begin
                        r_state_q <= R_RESP;
                        rvalid_q  <= 1'b1;
                        rdata_q   <= rdata_d;
                        // The head byte is captured in rdata_q at the same edge as the pop.
                        rd_en_q   <= (S_AXI_ARADDR[3:2] == ADDR_RXDATA) && !uart_rx_empty;
                    end
                end
                R_RESP: begin
                    if (S_AXI_RREADY) begin
                        r_state_q <= R_IDLE;
                        rvalid_q  <= 1'b0;
                    end
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

    assign S_AXI_RVALID = rvalid_q;
    assign S_AXI_RDATA  = rdata_q;
    assign S_AXI_RRESP  = AXI_RESP_OKAY;
    assign uart_rd_en   = rd_en_q;

endmodule

// File: tb/tb_axil_uart_slave.sv
// Scoreboard bench for axil_uart_slave: expected responses and TX bytes are
// queued at drive time and compared when the DUT produces them.
module tb_axil_uart_slave;
    import axil_uart_pkg::*;

    localparam int TMO = 20;

    logic        Clk, Resetn;
    logic [3:0]  S_AXI_AWADDR;
    logic        S_AXI_AWVALID, S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA;
    logic [3:0]  S_AXI_WSTRB;
    logic        S_AXI_WVALID, S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID, S_AXI_BREADY;
    logic [3:0]  S_AXI_ARADDR;
    logic        S_AXI_ARVALID, S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID, S_AXI_RREADY;
    logic [7:0]  uart_rx_data;
    logic        uart_rx_empty, uart_rd_en;
    logic [7:0]  uart_tx_data;
    logic        uart_wr_en, uart_tx_full, uart_enable_rx;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_pops = 0;
    int got_pops = 0;
    logic m_ctrl = 1'b0;

    logic [1:0]  exp_b[$];
    logic [31:0] exp_r[$];
    logic [7:0]  exp_tx[$];

    axil_uart_slave #(.C_ADDR_WIDTH(4), .C_DATA_WIDTH(32)) dut (
        .Clk(Clk), .Resetn(Resetn),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
        .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RVALID(S_AXI_RVALID),
        .S_AXI_RREADY(S_AXI_RREADY),
        .uart_rx_data(uart_rx_data), .uart_rx_empty(uart_rx_empty), .uart_rd_en(uart_rd_en),
        .uart_tx_data(uart_tx_data), .uart_wr_en(uart_wr_en), .uart_tx_full(uart_tx_full),
        .uart_enable_rx(uart_enable_rx)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Push/pop strobes are observed here, away from the active edge.
    always @(negedge Clk) begin
        if (Resetn) begin
            if (uart_wr_en) begin
                if (exp_tx.size() == 0) check("spurious_push", 1, 0);
                else check("tx_data", uart_tx_data, exp_tx.pop_front());
                check("wr_en_with_bvalid", S_AXI_BVALID, 1);
            end
            if (uart_rd_en) begin
                got_pops++;
                check("rd_en_with_rvalid", S_AXI_RVALID, 1);
            end
        end
    end

    function automatic logic [31:0] model_rdata(input logic [3:0] addr);
        logic [31:0] e;
        e = '0;
        case (addr[3:2])
            ADDR_RXDATA: if (!uart_rx_empty) e = {23'b0, 1'b1, uart_rx_data};
            ADDR_STATUS: e = {29'b0, m_ctrl, uart_tx_full, !uart_rx_empty};
            ADDR_CTRL:   e = {31'b0, m_ctrl};
            default:     e = '0;
        endcase
        return e;
    endfunction

    task automatic do_write(input logic [3:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int aw_lead, input int b_delay);
        logic [1:0] resp;
        int n;
        resp = AXI_RESP_OKAY;
        if (addr[3:2] == ADDR_TXDATA && strb[0]) begin
            if (uart_tx_full) resp = AXI_RESP_SLVERR;
            else exp_tx.push_back(data[7:0]);
        end
        exp_b.push_back(resp);

        @(posedge Clk); #1;
        S_AXI_AWADDR = addr; S_AXI_AWVALID = 1'b1;
        if (aw_lead == 0) begin
            S_AXI_WDATA = data; S_AXI_WSTRB = strb; S_AXI_WVALID = 1'b1;
        end
        n = 0;
        @(negedge Clk);
        while (!(S_AXI_AWREADY && (aw_lead != 0 || S_AXI_WREADY)) && n < TMO) begin
            n++; @(negedge Clk);
        end
        if (n >= TMO) check("aw_timeout", 0, 1);
        @(posedge Clk); #1;
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;

        if (aw_lead != 0) begin
            check("awready_while_held", S_AXI_AWREADY, 0);
            check("no_early_bvalid", S_AXI_BVALID, 0);
            repeat (aw_lead - 1) begin @(posedge Clk); #1; end
            S_AXI_WDATA = data; S_AXI_WSTRB = strb; S_AXI_WVALID = 1'b1;
            n = 0;
            @(negedge Clk);
            while (!S_AXI_WREADY && n < TMO) begin n++; @(negedge Clk); end
            if (n >= TMO) check("w_timeout", 0, 1);
            @(posedge Clk); #1;
            S_AXI_WVALID = 1'b0;
        end
        check("b_latency", S_AXI_BVALID, 1);
        if (addr[3:2] == ADDR_CTRL && strb[0]) m_ctrl = data[0];

        repeat (b_delay) begin
            @(negedge Clk);
            check("b_hold_valid", S_AXI_BVALID, 1);
            check("b_hold_resp", S_AXI_BRESP, exp_b[0]);
            check("b_hold_ready", {S_AXI_AWREADY, S_AXI_WREADY}, 0);
            @(posedge Clk); #1;
        end
        S_AXI_BREADY = 1'b1;
        n = 0;
        @(negedge Clk);
        while (!S_AXI_BVALID && n < TMO) begin n++; @(negedge Clk); end
        if (n >= TMO) check("b_timeout", 0, 1);
        check("bresp", S_AXI_BRESP, exp_b.pop_front());
        @(posedge Clk); #1;
        S_AXI_BREADY = 1'b0;
        check("b_clear", S_AXI_BVALID, 0);
    endtask

    task automatic do_read(input logic [3:0] addr, input int r_delay);
        logic [31:0] exp;
        int n;
        @(posedge Clk); #1;
        S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1;
        n = 0;
        @(negedge Clk);
        while (!S_AXI_ARREADY && n < TMO) begin n++; @(negedge Clk); end
        if (n >= TMO) check("ar_timeout", 0, 1);
        exp_r.push_back(model_rdata(addr));
        if (addr[3:2] == ADDR_RXDATA && !uart_rx_empty) exp_pops++;
        @(posedge Clk); #1;
        S_AXI_ARVALID = 1'b0;
        check("r_latency", S_AXI_RVALID, 1);
        exp = exp_r.pop_front();

        repeat (r_delay) begin
            @(negedge Clk);
            check("r_hold_data", S_AXI_RDATA, exp);
            check("r_hold_valid", S_AXI_RVALID, 1);
            check("r_hold_arready", S_AXI_ARREADY, 0);
            @(posedge Clk); #1;
        end
        S_AXI_RREADY = 1'b1;
        n = 0;
        @(negedge Clk);
        while (!S_AXI_RVALID && n < TMO) begin n++; @(negedge Clk); end
        if (n >= TMO) check("r_timeout", 0, 1);
        check("rdata", S_AXI_RDATA, exp);
        check("rresp", S_AXI_RRESP, AXI_RESP_OKAY);
        @(posedge Clk); #1;
        S_AXI_RREADY = 1'b0;
        check("r_clear", S_AXI_RVALID, 0);
    endtask

    initial begin
        Resetn = 1'b0;
        S_AXI_AWADDR = '0; S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0;
        S_AXI_BREADY = 1'b0;
        S_AXI_ARADDR = '0; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;
        uart_rx_data = 8'h00; uart_rx_empty = 1'b1; uart_tx_full = 1'b0;
        repeat (3) @(negedge Clk);
        Resetn = 1'b1;
        @(negedge Clk);

        check("rst_ready", {S_AXI_ARREADY, S_AXI_AWREADY, S_AXI_WREADY}, 3'b111);
        check("rst_valid", {S_AXI_BVALID, S_AXI_RVALID}, 0);
        check("rst_bresp", S_AXI_BRESP, 0);
        check("rst_rdata", S_AXI_RDATA, 0);
        check("rst_strobes", {uart_rd_en, uart_wr_en}, 0);
        check("rst_tx_data", uart_tx_data, 0);
        check("rst_enable_rx", uart_enable_rx, 0);

        // CTRL write enables the receiver; STATUS reflects it.
        do_write(4'hC, 32'h1, 4'hF, 0, 0);
        check("enable_rx_set", uart_enable_rx, 1);
        do_read(4'h8, 0);

        // TX push with AW leading W by 3 cycles.
        do_write(4'h4, 32'h0000_00A5, 4'hF, 3, 0);

        // TX push while full is dropped with SLVERR.
        uart_tx_full = 1'b1;
        do_write(4'h4, 32'h5A, 4'hF, 0, 0);
        uart_tx_full = 1'b0;

        // RX pop with data available, then with FIFO empty.
        uart_rx_empty = 1'b0; uart_rx_data = 8'h3C;
        do_read(4'h0, 0);
        check("pops_after_rx", got_pops, exp_pops);
        uart_rx_empty = 1'b1;
        do_read(4'h0, 0);
        check("pops_after_empty", got_pops, exp_pops);

        // Back-pressure on both response channels.
        uart_rx_empty = 1'b0; uart_rx_data = 8'h77;
        do_read(4'h0, 5);
        uart_rx_empty = 1'b1;
        check("pops_after_stall", got_pops, exp_pops);
        do_write(4'h4, 32'h11, 4'hF, 0, 5);

        // Byte lane 0 disabled: no push, CTRL unchanged.
        do_write(4'h4, 32'h22, 4'b0010, 0, 0);
        do_write(4'hC, 32'h0, 4'b1110, 0, 0);
        do_read(4'hC, 0);
        check("ctrl_kept", uart_enable_rx, 1);

        // Concurrent CTRL write and STATUS read: read sees the old CTRL.
        uart_rx_empty = 1'b0; uart_tx_full = 1'b1;
        fork
            do_write(4'hC, 32'h0, 4'hF, 0, 0);
            do_read(4'h8, 0);
        join
        do_read(4'h8, 0);
        uart_rx_empty = 1'b1; uart_tx_full = 1'b0;

        // Writes to RO offsets are ignored with OKAY; TXDATA reads back 0.
        do_write(4'h8, 32'hFFFF_FFFF, 4'hF, 2, 0);
        do_write(4'h0, 32'hFFFF_FFFF, 4'hF, 0, 0);
        do_read(4'h4, 0);

        // Reset while the write response is pending.
        @(posedge Clk); #1;
        S_AXI_AWADDR = 4'hC; S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA = 32'h1; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        @(negedge Clk);
        check("rst_test_ready", {S_AXI_AWREADY, S_AXI_WREADY}, 2'b11);
        @(posedge Clk); #1;
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        check("rst_test_bvalid_pre", S_AXI_BVALID, 1);
        #2 Resetn = 1'b0;
        #1;
        check("rst_test_bvalid", S_AXI_BVALID, 0);
        check("rst_test_ctrl", uart_enable_rx, 0);
        check("rst_test_ready_held", {S_AXI_AWREADY, S_AXI_WREADY}, 2'b11);
        m_ctrl = 1'b0;
        @(negedge Clk);
        Resetn = 1'b1;

        do_write(4'h4, 32'hC3, 4'hF, 0, 0);
        do_read(4'hC, 0);

        repeat (3) @(negedge Clk);
        check("tx_queue_drained", exp_tx.size(), 0);
        check("pop_count", got_pops, exp_pops);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
